instruction_fetch: RTL and testbench

- Producer of the instruction stream consumed by the decoder. Drives `instruction_data` / `instruction_data_valid` plus the matching PC.
- Issues word fetches to instruction memory over a request/response interface and buffers fetched words in a small FIFO.
- Handles pipeline redirects (branches/jumps resolved downstream): flushes the buffer and drops stale in-flight responses.

---
 rtl/instruction_fetch.sv | 148 ++++++++++++++
 tb/tb_instruction_fetch.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetches instruction words from memory over a req/resp
// interface, buffers them with their PCs in a small FIFO and handles
// downstream redirects, including dropping stale in-flight responses.
module instruction_fetch #(
  parameter int unsigned              INSTRUCTION_WIDTH = 32,
  parameter int unsigned              ADDRESS_WIDTH     = 32,
  parameter int unsigned              BUFFER_DEPTH      = 2,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC          = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [ADDRESS_WIDTH-1:0]     mem_addr,
  input  logic                         mem_resp_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] mem_resp_data,
  output logic [INSTRUCTION_WIDTH-1:0] instruction_data,
  output logic                         instruction_data_valid,
  output logic [ADDRESS_WIDTH-1:0]     instruction_pc,
  input  logic                         instruction_ready,
  input  logic                         redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0]     redirect_pc,
  output logic                         fetch_fault
);

  localparam int unsigned PTR_W = $clog2(BUFFER_DEPTH);
  localparam int unsigned CNT_W = $clog2(BUFFER_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUFFER_DEPTH);

  typedef enum logic [2:0] {
    ST_REQUEST,
    ST_WAIT,
    ST_FULL,
    ST_DISCARD,
    ST_HALT
  } state_t;

  state_t                         state;
  logic [ADDRESS_WIDTH-1:0]       pc;
  logic                           fault;

  logic [INSTRUCTION_WIDTH-1:0]   data_mem [BUFFER_DEPTH];
  logic [ADDRESS_WIDTH-1:0]       pc_mem   [BUFFER_DEPTH];
  logic [PTR_W-1:0]               wr_ptr;
  logic [PTR_W-1:0]               rd_ptr;
  logic [CNT_W-1:0]               count;

  logic                           credit;
  logic                           req_fire;
  logic                           pop;
  logic                           push;
  logic                           redirect_take;
  logic                           redirect_bad;
  logic [CNT_W-1:0]               count_after_push;
  logic                           room_after_push;

  // Handshake qualifiers, credit check and output views of the FIFO head
  always_comb begin
    // Only one request can be outstanding, and none is while in REQUEST,
    // so the credit test reduces to FIFO occupancy alone.
    credit                 = count < DEPTH_C;
    mem_req_valid          = rst && (state == ST_REQUEST) && credit;
    req_fire               = mem_req_valid && mem_req_ready;
    instruction_data_valid = count != '0;
    pop                    = instruction_data_valid && instruction_ready;
    redirect_take          = redirect_valid && (state != ST_HALT);
    redirect_bad           = redirect_take && (redirect_pc[1:0] != 2'b00);
    push                   = (state == ST_WAIT) && mem_resp_valid && !redirect_take;
    count_after_push       = count + CNT_W'(1) - CNT_W'(pop);
    room_after_push        = count_after_push < DEPTH_C;
    mem_addr               = pc;
    instruction_data       = data_mem[rd_ptr];
    instruction_pc         = pc_mem[rd_ptr];
    fetch_fault            = fault;
  end

  // FIFO storage: fetched word paired with the PC it was fetched from
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= mem_resp_data;
      pc_mem[wr_ptr]   <= pc;
    end
  end

  // FIFO pointers and occupancy; any redirect empties the buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_take) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Fetch sequencer: tracks the outstanding request, PC and fault state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_REQUEST;
      pc    <= RESET_PC;
      fault <= 1'b0;
    end else if (redirect_bad) begin
      state <= ST_HALT;
      fault <= 1'b1;
    end else if (redirect_take) begin
      // An accepted request or an unanswered one leaves a response in
      // flight that must be swallowed before fetching from the new PC.
      pc <= redirect_pc;
      case (state)
        ST_REQUEST: state <= req_fire       ? ST_DISCARD : ST_REQUEST;
        ST_WAIT:    state <= mem_resp_valid ? ST_REQUEST : ST_DISCARD;
        ST_DISCARD: state <= mem_resp_valid ? ST_REQUEST : ST_DISCARD;
        default:    state <= ST_REQUEST;
      endcase
    end else begin
      case (state)
        ST_REQUEST: begin
          if (!credit)       state <= ST_FULL;
          else if (req_fire) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_resp_valid) begin
            pc    <= pc + ADDRESS_WIDTH'(4);
            state <= room_after_push ? ST_REQUEST : ST_FULL;
          end
        end
        ST_FULL: begin
          if (pop) state <= ST_REQUEST;
        end
        ST_DISCARD: begin
          if (mem_resp_valid) state <= ST_REQUEST;
        end
        default: state <= ST_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: stimulus pushes expected output
// words, a monitor pops and compares on each consumer pop and checks fetch
// addresses, and a memory model answers accepted requests after `lat` cycles.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic [31:0] instruction_data;
  logic        instruction_data_valid;
  logic [31:0] instruction_pc;
  logic        instruction_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  always #5 clk = ~clk;

  instruction_fetch #(
    .INSTRUCTION_WIDTH(32),
    .ADDRESS_WIDTH    (32),
    .BUFFER_DEPTH     (2),
    .RESET_PC         (32'h0000_0000)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .mem_req_valid         (mem_req_valid),
    .mem_req_ready         (mem_req_ready),
    .mem_addr              (mem_addr),
    .mem_resp_valid        (mem_resp_valid),
    .mem_resp_data         (mem_resp_data),
    .instruction_data      (instruction_data),
    .instruction_data_valid(instruction_data_valid),
    .instruction_pc        (instruction_pc),
    .instruction_ready     (instruction_ready),
    .redirect_valid        (redirect_valid),
    .redirect_pc           (redirect_pc),
    .fetch_fault           (fetch_fault)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // stimulus-owned
  int          lat = 1;
  int          addr_seq = 0;
  logic [31:0] addr_new = 32'h0;
  // monitor-owned
  int          addr_seen = 0;
  logic [31:0] exp_addr = 32'h0;
  int          hs_count = 0;
  bit          pend_v = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          acc_cyc = 0;
  // memory-owned
  int          cyc = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: answers `lat` cycles after acceptance, just after the edge
  initial begin
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      mem_resp_valid = pend_v && ((cyc - acc_cyc) >= lat);
      mem_resp_data  = mem_resp_valid ? word_of(pend_addr) : 32'h0;
    end
  end

  // Monitor: samples one time unit before each rising edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (addr_seq != addr_seen) begin
        exp_addr  = addr_new;
        addr_seen = addr_seq;
      end
      if (!rst) begin
        pend_v = 1'b0;
      end else begin
        if (mem_resp_valid) pend_v = 1'b0;
        if (mem_req_valid && mem_req_ready) begin
          chk("fetch_addr", mem_addr, exp_addr);
          chk("fetch_align", {30'd0, mem_addr[1:0]}, 32'd0);
          exp_addr  = exp_addr + 32'd4;
          hs_count++;
          pend_v    = 1'b1;
          pend_addr = mem_addr;
          acc_cyc   = cyc;
        end
        if (instruction_data_valid && instruction_ready && !redirect_valid && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("out_pc", instruction_pc, e.pc);
          chk("out_data", instruction_data, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_addr(input logic [31:0] a);
    addr_new = a;
    addr_seq++;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back('{pc, word_of(pc)});
  endtask

  task automatic do_reset();
    tick();
    rst               = 1'b0;
    redirect_valid    = 1'b0;
    instruction_ready = 1'b0;
    mem_req_ready     = 1'b0;
    exp_q.delete();
    set_addr(32'h0);
    #1;
    chk("rst_valid", 32'(instruction_data_valid), 32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    tick();
    tick();
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (exp_q.size() == 0) break;
    end
    chk(name, exp_q.size(), 32'd0);
    instruction_ready = 1'b0;
    mem_req_ready     = 1'b0;
  endtask

  task automatic wait_resp(input string name);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_resp_valid) break;
    end
    chk(name, 32'(mem_resp_valid), 32'd1);
  endtask

  initial begin
    int h0;
    rst               = 1'b0;
    mem_req_ready     = 1'b0;
    instruction_ready = 1'b0;
    redirect_valid    = 1'b0;
    redirect_pc       = 32'h0;

    // Streaming from reset, one-cycle memory, consumer always ready
    do_reset();
    lat = 1;
    for (int i = 0; i < 8; i++) push_exp(32'(i * 4));
    tick();
    rst = 1'b1; mem_req_ready = 1'b1; instruction_ready = 1'b1;
    #4;
    chk("t1_first_req", 32'(mem_req_valid), 32'd1);
    chk("t1_first_addr", mem_addr, 32'h0);
    tick(); #4;
    chk("t1_valid_before", 32'(instruction_data_valid), 32'd0);
    chk("t1_resp_seen", 32'(mem_resp_valid), 32'd1);
    tick(); #4;
    chk("t1_valid_rise", 32'(instruction_data_valid), 32'd1);
    chk("t1_first_pc", instruction_pc, 32'h0);
    wait_drain("t1_drain");

    // Consumer stalled: two fetches fill the buffer, one pop frees a slot
    do_reset();
    lat = 1;
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
    tick();
    rst = 1'b1; mem_req_ready = 1'b1; instruction_ready = 1'b0;
    h0 = hs_count;
    repeat (8) tick();
    #4;
    chk("t2_req_count", 32'(hs_count - h0), 32'd2);
    chk("t2_full_no_req", 32'(mem_req_valid), 32'd0);
    chk("t2_head_valid", 32'(instruction_data_valid), 32'd1);
    chk("t2_head_pc", instruction_pc, 32'h0);
    tick();
    instruction_ready = 1'b1;
    tick();
    instruction_ready = 1'b0;
    #4;
    chk("t2_refill_req", 32'(mem_req_valid), 32'd1);
    chk("t2_refill_addr", mem_addr, 32'h8);
    tick();
    instruction_ready = 1'b1;
    wait_drain("t2_drain");

    // Redirect to 0x100 while waiting; the late old response is dropped
    do_reset();
    lat = 2;
    push_exp(32'h100); push_exp(32'h104); push_exp(32'h108);
    tick();
    rst = 1'b1; mem_req_ready = 1'b1; instruction_ready = 1'b1;
    tick();
    chk("t3_wait_no_resp", 32'(mem_resp_valid), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h100; set_addr(32'h100);
    tick();
    redirect_valid = 1'b0;
    #4;
    chk("t3_discard_no_req", 32'(mem_req_valid), 32'd0);
    chk("t3_stale_resp", 32'(mem_resp_valid), 32'd1);
    tick(); #4;
    chk("t3_flushed", 32'(instruction_data_valid), 32'd0);
    chk("t3_new_req", 32'(mem_req_valid), 32'd1);
    chk("t3_new_addr", mem_addr, 32'h100);
    wait_drain("t3_drain");

    // Redirect to 0x200 coinciding with the response in WAIT
    do_reset();
    lat = 1;
    push_exp(32'h200); push_exp(32'h204);
    tick();
    rst = 1'b1; mem_req_ready = 1'b1; instruction_ready = 1'b1;
    wait_resp("t4_resp");
    redirect_valid = 1'b1; redirect_pc = 32'h200; set_addr(32'h200);
    tick();
    redirect_valid = 1'b0;
    #4;
    chk("t4_not_pushed", 32'(instruction_data_valid), 32'd0);
    chk("t4_req", 32'(mem_req_valid), 32'd1);
    chk("t4_addr", mem_addr, 32'h200);
    wait_drain("t4_drain");

    // Misaligned redirect in WAIT with a response: halt until reset
    do_reset();
    lat = 1;
    push_exp(32'h0);
    tick();
    rst = 1'b1; mem_req_ready = 1'b1; instruction_ready = 1'b1;
    wait_resp("t5_resp0");
    wait_resp("t5_resp1");
    redirect_valid = 1'b1; redirect_pc = 32'h102; set_addr(32'hDEAD_BEEF);
    tick();
    redirect_valid = 1'b0;
    #4;
    chk("t5_fault", 32'(fetch_fault), 32'd1);
    chk("t5_no_valid", 32'(instruction_data_valid), 32'd0);
    chk("t5_no_req", 32'(mem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(); #4;
      chk("t5_fault_sticky", 32'(fetch_fault), 32'd1);
      chk("t5_halt_no_req", 32'(mem_req_valid), 32'd0);
      chk("t5_halt_no_valid", 32'(instruction_data_valid), 32'd0);
    end
    chk("t5_drain", exp_q.size(), 32'd0);

    // PC wrap at the top of the address space, then reset mid-WAIT
    do_reset();
    lat = 1;
    tick();
    h0 = hs_count;
    rst = 1'b1; mem_req_ready = 1'b0; instruction_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; set_addr(32'hFFFF_FFFC);
    tick();
    redirect_valid = 1'b0; mem_req_ready = 1'b1;
    #4;
    chk("t6_retarget_addr", mem_addr, 32'hFFFF_FFFC);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (hs_count - h0 >= 2) break;
    end
    chk("t6_two_fetches", 32'(hs_count - h0), 32'd2);
    chk("t6_head_valid", 32'(instruction_data_valid), 32'd1);
    chk("t6_head_pc", instruction_pc, 32'hFFFF_FFFC);
    chk("t6_head_data", instruction_data, word_of(32'hFFFF_FFFC));
    rst = 1'b0;
    set_addr(32'h0);
    #1;
    chk("t6_rst_valid", 32'(instruction_data_valid), 32'd0);
    chk("t6_rst_fault", 32'(fetch_fault), 32'd0);
    chk("t6_rst_req", 32'(mem_req_valid), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    #4;
    chk("t6_after_rst_req", 32'(mem_req_valid), 32'd1);
    chk("t6_after_rst_addr", mem_addr, 32'h0);
    tick();
    mem_req_ready = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
